// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared types for the pipeline hazard sequencer: FSM states, control bundle
// layout and the default divider latency.
package pipe_stall_ctrl_pkg;

  localparam int unsigned DIV_CYCLES_DEFAULT = 32;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    IWAIT   = 2'd1,
    DWAIT   = 2'd2,
    DIVBUSY = 2'd3
  } stall_state_t;

  // stall bits index F/D/E/M registers, flush bits index D/E/M/W registers
  localparam int unsigned SF = 0;
  localparam int unsigned SD = 1;
  localparam int unsigned SE = 2;
  localparam int unsigned SM = 3;
  localparam int unsigned FD = 0;
  localparam int unsigned FE = 1;
  localparam int unsigned FM = 2;
  localparam int unsigned FW = 3;

  typedef struct packed {
    logic [3:0] stall;
    logic [3:0] flush;
  } hazard_ctrl_t;

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// Hazard interface between the core datapath (master) and the stall/flush
// sequencer (slave).
interface pipe_stall_ctrl_if;
  logic i_req;
  logic i_data_ok;
  logic d_req;
  logic d_data_ok;
  logic div_startE;
  logic load_useD;
  logic excM;
  logic stallF;
  logic stallD;
  logic stallE;
  logic stallM;
  logic flushD;
  logic flushE;
  logic flushM;
  logic flushW;
  logic i_discard;
  logic div_done;

  modport master (
    output i_req, i_data_ok, d_req, d_data_ok, div_startE, load_useD, excM,
    input  stallF, stallD, stallE, stallM, flushD, flushE, flushM, flushW,
    input  i_discard, div_done
  );

  modport slave (
    input  i_req, i_data_ok, d_req, d_data_ok, div_startE, load_useD, excM,
    output stallF, stallD, stallE, stallM, flushD, flushE, flushM, flushW,
    output i_discard, div_done
  );
endinterface

// File: rtl/pipe_stall_ctrl_div_busy_counter.sv
// Divider occupancy counter: loads DIV_CYCLES-1 on start, counts down while
// busy, flags the final cycle, and is cleared by a pipeline flush.
module pipe_stall_ctrl_div_busy_counter #(
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic busy,
  input  logic flush,
  output logic done_c
);
  localparam int unsigned CW = $clog2(DIV_CYCLES + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else if (start) begin
      count <= CW'(DIV_CYCLES - 1);
    end else if (busy && (count != '0)) begin
      count <= count - CW'(1);
    end
  end

  assign done_c = busy && (count == '0);

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline hazard sequencer: merges fetch/data handshakes, divider occupancy,
// load-use and exception redirect into per-stage stall/flush controls.
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEFAULT
) (
  input logic              clk,
  input logic              reset,
  pipe_stall_ctrl_if.slave hz
);

  stall_state_t state;
  logic         ipend;
  logic         idrop;
  logic         exc_lat;
  logic         dstall_c;
  logic         exc_fire_c;
  logic         div_start_c;
  logic         div_stall_c;
  logic         div_done_c;
  logic         istall_c;
  hazard_ctrl_t ctl;

  // Hazard causes; M is flushed while the divider runs, so no d_req is seen there
  always_comb begin
    dstall_c    = (state == DWAIT) ? !hz.d_data_ok
                                   : ((state != DIVBUSY) && hz.d_req && !hz.d_data_ok);
    exc_fire_c  = !dstall_c && (hz.excM || exc_lat);
    div_start_c = (state != DIVBUSY) && !dstall_c && !exc_fire_c && hz.div_startE;
    div_stall_c = div_start_c || ((state == DIVBUSY) && !div_done_c);
    istall_c    = (hz.i_req || ipend) && !hz.i_data_ok;
  end

  pipe_stall_ctrl_div_busy_counter #(
    .DIV_CYCLES(DIV_CYCLES)
  ) u_div_cnt (
    .clk   (clk),
    .reset (reset),
    .start (div_start_c),
    .busy  (state == DIVBUSY),
    .flush (exc_fire_c),
    .done_c(div_done_c)
  );

  // Priority mux: data wait > redirect > divider > fetch wait > load-use
  always_comb begin
    ctl = '0;
    if (!reset) begin
      if (dstall_c) begin
        ctl.stall     = 4'b1111;
        ctl.flush[FW] = 1'b1;
      end else if (exc_fire_c) begin
        ctl.flush[FD] = 1'b1;
        ctl.flush[FE] = 1'b1;
        ctl.flush[FM] = 1'b1;
      end else if (div_stall_c) begin
        ctl.stall[SF] = 1'b1;
        ctl.stall[SD] = 1'b1;
        ctl.stall[SE] = 1'b1;
        ctl.flush[FM] = 1'b1;
      end else if (istall_c) begin
        ctl.stall[SF] = 1'b1;
        ctl.flush[FD] = 1'b1;
      end else if (hz.load_useD) begin
        ctl.stall[SF] = 1'b1;
        ctl.stall[SD] = 1'b1;
        ctl.flush[FE] = 1'b1;
      end
    end
  end

  assign hz.stallF    = ctl.stall[SF];
  assign hz.stallD    = ctl.stall[SD];
  assign hz.stallE    = ctl.stall[SE];
  assign hz.stallM    = ctl.stall[SM];
  assign hz.flushD    = ctl.flush[FD];
  assign hz.flushE    = ctl.flush[FE];
  assign hz.flushM    = ctl.flush[FM];
  assign hz.flushW    = ctl.flush[FW];
  assign hz.i_discard = !reset && idrop && hz.i_data_ok;
  assign hz.div_done  = !reset && div_done_c && !exc_fire_c;

  // A redirect with a fetch in flight marks the returning data as stale
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= RUN;
      ipend   <= 1'b0;
      idrop   <= 1'b0;
      exc_lat <= 1'b0;
    end else begin
      ipend   <= !hz.i_data_ok && (ipend || hz.i_req);
      idrop   <= !hz.i_data_ok && (idrop || (exc_fire_c && (ipend || hz.i_req)));
      exc_lat <= dstall_c && (exc_lat || hz.excM);
      if (dstall_c) begin
        state <= DWAIT;
      end else if (div_stall_c && !exc_fire_c) begin
        state <= DIVBUSY;
      end else if (!hz.i_data_ok && (ipend || hz.i_req)) begin
        state <= IWAIT;
      end else begin
        state <= RUN;
      end
    end
  end

  a_one_fetch: assert property (@(posedge clk) disable iff (reset) !(hz.i_req && ipend));
  a_stall_order: assert property (@(posedge clk) disable iff (reset)
    ctl.stall inside {4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111});
  a_stall_xor_flush: assert property (@(posedge clk) disable iff (reset)
    (ctl.stall[3:1] & ctl.flush[2:0]) == 3'b000);

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: directed vector table, multi-cycle
// divider/reset sequences and constrained-random traffic against a cycle model.
module tb_pipe_stall_ctrl;

  localparam int DIVC = 32;

  // input packing {i_req, i_data_ok, d_req, d_data_ok, div_startE, load_useD, excM}
  localparam logic [6:0] I_IREQ = 7'b1000000;
  localparam logic [6:0] I_IOK  = 7'b0100000;
  localparam logic [6:0] I_DREQ = 7'b0010000;
  localparam logic [6:0] I_DOK  = 7'b0001000;
  localparam logic [6:0] I_DIV  = 7'b0000100;
  localparam logic [6:0] I_LU   = 7'b0000010;
  localparam logic [6:0] I_EXC  = 7'b0000001;
  localparam logic [6:0] I_NONE = 7'b0000000;

  // output packing {stallF,D,E,M, flushD,E,M,W, i_discard, div_done}
  localparam logic [9:0] O_NONE = 10'b0000_0000_00;
  localparam logic [9:0] O_IW   = 10'b1000_1000_00;
  localparam logic [9:0] O_LU   = 10'b1100_0100_00;
  localparam logic [9:0] O_DW   = 10'b1111_0001_00;
  localparam logic [9:0] O_EX   = 10'b0000_1110_00;
  localparam logic [9:0] O_DV   = 10'b1110_0010_00;
  localparam logic [9:0] O_DISC = 10'b0000_0000_10;
  localparam logic [9:0] O_DONE = 10'b0000_0000_01;

  typedef struct {
    logic [6:0] in;
    logic [9:0] exp;
    string      name;
  } vec_t;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;
  vec_t tbl[$];

  // reference model state
  bit m_fetch_wait;
  bit m_fetch_stale;
  bit m_dwait;
  bit m_exc_held;
  bit div_want;
  int m_div_left;

  pipe_stall_ctrl_if hz ();

  pipe_stall_ctrl #(.DIV_CYCLES(DIVC)) dut (
    .clk  (clk),
    .reset(reset),
    .hz   (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic [6:0] in);
    {hz.i_req, hz.i_data_ok, hz.d_req, hz.d_data_ok, hz.div_startE, hz.load_useD, hz.excM} = in;
  endtask

  function automatic logic [9:0] outs();
    return {hz.stallF, hz.stallD, hz.stallE, hz.stallM,
            hz.flushD, hz.flushE, hz.flushM, hz.flushW, hz.i_discard, hz.div_done};
  endfunction

  task automatic check(input string name, input logic [9:0] got, input logic [9:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b (sF sD sE sM fD fE fM fW disc done)", name, got, exp);
    end
  endtask

  task automatic step(input logic [6:0] in, input logic [9:0] exp, input string name);
    @(negedge clk);
    drive(in);
    #2;
    check(name, outs(), exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    drive(I_NONE);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic add(input logic [6:0] in, input logic [9:0] exp, input string name);
    vec_t v;
    v.in = in;
    v.exp = exp;
    v.name = name;
    tbl.push_back(v);
  endtask

  // Cycle model: divider remaining-cycle count, outstanding fetch/data flags
  task automatic model_cycle(input logic [6:0] in, output logic [9:0] exp, output bit redirect);
    bit ireq, iok, dreq, dok, dv, lu, ex;
    bit mem_blocked, div_stall, done, fetch_stall;
    {ireq, iok, dreq, dok, dv, lu, ex} = in;
    mem_blocked = m_dwait ? !dok : (m_div_left == 0 && dreq && !dok);
    redirect    = !mem_blocked && (ex || m_exc_held);
    div_stall   = !mem_blocked && !redirect && ((m_div_left > 1) || (m_div_left == 0 && dv));
    done        = !mem_blocked && !redirect && (m_div_left == 1);
    fetch_stall = (ireq || m_fetch_wait) && !iok;
    if (mem_blocked)      exp = O_DW;
    else if (redirect)    exp = O_EX;
    else if (div_stall)   exp = O_DV;
    else if (fetch_stall) exp = O_IW;
    else if (lu)          exp = O_LU;
    else                  exp = O_NONE;
    exp[1] = iok && m_fetch_stale;
    exp[0] = done;

    m_exc_held = mem_blocked && (m_exc_held || ex);
    if (iok) begin
      m_fetch_wait  = 1'b0;
      m_fetch_stale = 1'b0;
    end else begin
      if (redirect && (m_fetch_wait || ireq)) m_fetch_stale = 1'b1;
      if (ireq) m_fetch_wait = 1'b1;
    end
    m_dwait = mem_blocked;
    if (redirect)             m_div_left = 0;
    else if (m_div_left > 0)  m_div_left = m_div_left - 1;
    else if (!mem_blocked && dv) m_div_left = DIVC;
  endtask

  initial begin
    logic [6:0] rin;
    logic [9:0] rexp;
    bit         redir;

    n_cmp = 0;
    n_bad = 0;

    // outputs must stay low while reset is held, whatever the inputs do
    reset = 1'b1;
    drive(I_IREQ | I_DREQ | I_LU | I_EXC);
    repeat (2) @(negedge clk);
    #2;
    check("reset_outputs", outs(), O_NONE);
    drive(I_NONE);
    @(negedge clk);
    reset = 1'b0;

    add(I_NONE,                O_NONE, "idle");
    add(I_LU,                  O_LU,   "load_use");
    add(I_NONE,                O_NONE, "load_use_one_cycle");
    add(I_IREQ | I_IOK,        O_NONE, "fetch_same_cycle");
    add(I_DREQ | I_DOK,        O_NONE, "dmem_same_cycle");
    add(I_IREQ,                O_IW,   "fetch_t0");
    add(I_NONE,                O_IW,   "fetch_t1");
    add(I_LU,                  O_IW,   "fetch_t2_over_lu");
    add(I_IOK,                 O_NONE, "fetch_t3");
    add(I_EXC,                 O_EX,   "exc_alone");
    add(I_DREQ,                O_DW,   "dw_t0");
    add(I_EXC,                 O_DW,   "dw_t1_exc_held");
    add(I_NONE,                O_DW,   "dw_t2");
    add(I_NONE,                O_DW,   "dw_t3");
    add(I_DOK,                 O_EX,   "dw_t4_exc_applied");
    add(I_NONE,                O_NONE, "dw_t5_exc_cleared");
    add(I_IREQ,                O_IW,   "drop_t0");
    add(I_EXC,                 O_EX,   "drop_t1_exc");
    add(I_IOK,                 O_DISC, "drop_t2_discard");
    add(I_IREQ | I_IOK,        O_NONE, "drop_cleared");
    add(I_IREQ | I_IOK | I_EXC, O_EX,  "exc_fetch_consumed");
    add(I_IREQ,                O_IW,   "consumed_next_fetch");
    add(I_IOK,                 O_NONE, "consumed_no_discard");
    add(I_EXC | I_LU,          O_EX,   "exc_over_lu");
    add(I_IREQ | I_EXC,        O_EX,   "exc_with_req");
    add(I_IOK,                 O_DISC, "req_exc_discard");
    add(I_DREQ | I_LU,         O_DW,   "dw_over_lu");
    add(I_DOK | I_LU,          O_LU,   "dw_exit_lu");
    add(I_DREQ | I_DIV,        O_DW,   "div_deferred");
    add(I_DOK | I_DIV,         O_DV,   "div_deferred_start");
    add(I_EXC,                 O_EX,   "exc_kills_div");
    add(I_NONE,                O_NONE, "after_div_kill");
    add(I_NONE,                O_NONE, "no_done_after_kill");

    foreach (tbl[i]) step(tbl[i].in, tbl[i].exp, tbl[i].name);

    // full divider occupancy: 32 stalled cycles, done pulse, then clear
    do_reset();
    step(I_DIV, O_DV, "div_start");
    for (int k = 1; k < DIVC; k++) step(I_NONE, O_DV, $sformatf("div_busy%0d", k));
    step(I_NONE, O_DONE, "div_done");
    step(I_NONE, O_NONE, "div_after");

    // reset while the divider counter reads 10
    do_reset();
    step(I_DIV, O_DV, "rst_div_start");
    for (int k = 1; k < 22; k++) step(I_NONE, O_DV, $sformatf("rst_div_busy%0d", k));
    step(I_NONE, O_DV, "rst_div_count10");
    reset = 1'b1;
    #1;
    check("rst_immediate", outs(), O_NONE);
    @(negedge clk);
    #2;
    check("rst_held", outs(), O_NONE);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 40; k++) step(I_NONE, O_NONE, $sformatf("rst_no_done%0d", k));
    step(I_IOK | I_DOK, O_NONE, "rst_late_acks");

    // constrained-random traffic against the cycle model
    do_reset();
    m_fetch_wait  = 1'b0;
    m_fetch_stale = 1'b0;
    m_dwait       = 1'b0;
    m_exc_held    = 1'b0;
    div_want      = 1'b0;
    m_div_left    = 0;
    for (int c = 0; c < 4000; c++) begin
      if (m_div_left == 0 && !div_want && $urandom_range(99) < 3) div_want = 1'b1;
      rin    = I_NONE;
      rin[6] = !m_fetch_wait && ($urandom_range(99) < 30);
      rin[5] = (m_fetch_wait || rin[6]) && ($urandom_range(99) < 40);
      rin[4] = !m_dwait && (m_div_left == 0) && ($urandom_range(99) < 15);
      rin[3] = (m_dwait || rin[4]) && ($urandom_range(99) < 35);
      rin[2] = div_want;
      rin[1] = $urandom_range(99) < 15;
      rin[0] = $urandom_range(99) < 4;
      @(negedge clk);
      drive(rin);
      #2;
      model_cycle(rin, rexp, redir);
      check($sformatf("rand_c%0d", c), outs(), rexp);
      if (redir || m_div_left != 0) div_want = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
